// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a load/store requester
// and the mem_responder data-memory slave.
//   req_valid/req_ready   : request handshake (requester -> responder)
//   req_write             : 1 = store word, 0 = load word
//   req_addr, req_wdata   : byte address and store data
//   resp_valid/resp_ready : response handshake (responder -> requester)
//   resp_rdata            : load data, 0 for stores and errors
//   resp_err              : misaligned or out-of-range request
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle word-wide data memory for a stallable MEM stage.
// Accepts one load/store at a time, waits WAIT_CYCLES wait states, commits the
// access to a DEPTH_WORDS x 32 register array, then holds the response until
// the requester takes it.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : mem_responder_if slave side (request and response handshakes)
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_next_s;
    logic              accept_s;
    logic              commit_s;
    logic              release_s;

    logic              write_r;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;

    logic              resp_valid_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;

    logic [31:0]       mem_r [DEPTH_WORDS];
    logic [IDX_W-1:0]  index_s;
    logic              err_s;
    logic              mem_we_s;

    // A request is in error when it is not word aligned or addresses a word
    // beyond the backing store.
    function automatic logic addr_is_error(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH_LIMIT);
    endfunction

    assign index_s  = addr_r[IDX_W+1:2];
    assign err_s    = addr_is_error(addr_r);
    assign mem_we_s = commit_s && write_r && !err_s;

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;

    // Next-state and control decode for the IDLE/WAIT/RESP handshake FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        commit_s     = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // req_ready is implied by being in IDLE.
                if (bus.req_valid) begin
                    accept_s     = 1'b1;
                    cnt_next_s   = WAIT_INIT;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r != 4'd0) begin
                    cnt_next_s   = cnt_r - 4'd1;
                    state_next_s = ST_WAIT;
                end else begin
                    commit_s     = 1'b1;
                    state_next_s = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    release_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait-state counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Capture the request on acceptance so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_r <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            write_r <= bus.req_write;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end
    end

    // Response registers: loaded at commit, held until the response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else if (commit_s) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= (write_r || err_s) ? 32'd0 : mem_r[index_s];
            resp_err_r   <= err_s;
        end else if (release_s) begin
            resp_valid_r <= 1'b0;
        end
    end

    // Backing store; not reset, and a reset on the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_r[index_s] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. Two instances are
// exercised: one with two wait states and one with none. A small word-array
// model holds the expected memory contents for a 16-word window.
module tb_mem_responder;

    logic clk;
    logic rst;
    int   cycle;
    int   errors;
    int   checks;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    typedef struct packed {
        logic        req_ready;
        logic        resp_valid;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic [31:0] model [2][16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic drv_req(input int sel, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a; bus_a.req_wdata = d;
        end else begin
            bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a; bus_b.req_wdata = d;
        end
    endtask

    task automatic drv_rr(input int sel, input logic v);
        if (sel == 0) bus_a.resp_ready = v;
        else          bus_b.resp_ready = v;
    endtask

    function automatic obs_t observe(input int sel);
        obs_t o;
        if (sel == 0) o = '{bus_a.req_ready, bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err};
        else          o = '{bus_b.req_ready, bus_b.resp_valid, bus_b.resp_rdata, bus_b.resp_err};
        return o;
    endfunction

    // Reference rules: word aligned and inside the 256-word store.
    function automatic logic ref_err(input logic [31:0] addr);
        return (addr % 32'd4 != 32'd0) || (addr / 32'd4 >= 32'd256);
    endfunction

    function automatic logic [31:0] ref_rdata(input int sel, input logic wr, input logic [31:0] addr);
        if (wr || ref_err(addr)) return 32'd0;
        return model[sel][addr / 32'd4];
    endfunction

    task automatic ref_apply(input int sel, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (wr && !ref_err(addr)) model[sel][addr / 32'd4] = wdata;
    endtask

    // One full transaction, entered and left at a negedge. stall = number of
    // response-valid cycles with resp_ready low; a stray request to 0x20 is
    // pulsed during the stall and must be ignored.
    task automatic txn(input int sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       output int acc);
        obs_t o;
        int   k;
        int   lat;
        int   exp_lat;
        exp_lat = (sel == 0) ? 3 : 1;
        drv_rr(sel, stall == 0);
        o = observe(sel);
        k = 0;
        while (!o.req_ready && k < 20) begin
            @(negedge clk); o = observe(sel); k++;
        end
        chk("req_ready_idle", 32'(o.req_ready), 32'd1);
        drv_req(sel, 1'b1, wr, addr, wdata);
        @(posedge clk); #1;
        acc = cycle;
        @(negedge clk);
        drv_req(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        o = observe(sel);
        lat = 0;
        while (!o.resp_valid && lat < 40) begin
            @(negedge clk); lat++; o = observe(sel);
        end
        chk("resp_valid_arrives", 32'(o.resp_valid), 32'd1);
        chk("latency", lat, exp_lat);
        chk("resp_rdata", o.rdata, exp_rdata);
        chk("resp_err", 32'(o.err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(o.resp_valid), 32'd1);
            chk("stall_rdata", o.rdata, exp_rdata);
            chk("stall_req_ready", 32'(o.req_ready), 32'd0);
            if (i == 1) drv_req(sel, 1'b1, 1'b1, 32'h20, 32'hBAD0_BAD0);
            else        drv_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk); o = observe(sel);
        end
        drv_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        drv_rr(sel, 1'b1);
        @(negedge clk); o = observe(sel);
        chk("released_valid", 32'(o.resp_valid), 32'd0);
        chk("released_req_ready", 32'(o.req_ready), 32'd1);
    endtask

    initial begin
        vec_t        vecs [8];
        obs_t        o;
        int          acc;
        int          prev_acc;
        logic        seen;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;

        clk = 1'b0; rst = 1'b1; cycle = 0; errors = 0; checks = 0;
        drv_req(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111);
        drv_req(1, 1'b1, 1'b1, 32'h10, 32'h1111_1111);
        drv_rr(0, 1'b0);
        drv_rr(1, 1'b0);

        // Reset held two edges with req_valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            chk("rst_req_ready", 32'(o.req_ready), 32'd1);
            chk("rst_resp_valid", 32'(o.resp_valid), 32'd0);
            chk("rst_resp_rdata", o.rdata, 32'd0);
            chk("rst_resp_err", 32'(o.err), 32'd0);
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            o = observe(s);
            chk("rst_no_accept", 32'(o.req_ready), 32'd1);
        end

        // Preload a 16-word window in both instances.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                txn(s, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 0, 32'd0, 1'b0, acc);
                ref_apply(s, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i));
            end
        end

        // Directed vectors on the two-wait-state instance.
        vecs[0] = '{1'b1, 32'h10,  32'hDEAD_BEEF, 0, 32'd0,          1'b0};
        vecs[1] = '{1'b0, 32'h10,  32'h0,         0, 32'hDEAD_BEEF,  1'b0};
        vecs[2] = '{1'b0, 32'h10,  32'h0,         5, 32'hDEAD_BEEF,  1'b0};
        vecs[3] = '{1'b1, 32'h13,  32'h1234_5678, 0, 32'd0,          1'b1};
        vecs[4] = '{1'b1, 32'h400, 32'h1234_5678, 0, 32'd0,          1'b1};
        vecs[5] = '{1'b0, 32'h10,  32'h0,         0, 32'hDEAD_BEEF,  1'b0};
        vecs[6] = '{1'b0, 32'h0,   32'h0,         0, 32'hA500_0000,  1'b0};
        vecs[7] = '{1'b0, 32'h20,  32'h0,         0, 32'hA500_0008,  1'b0};
        foreach (vecs[i]) begin
            txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].stall,
                vecs[i].exp_rdata, vecs[i].exp_err, acc);
            ref_apply(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
        end

        // Reset one cycle after accepting a write: request must be abandoned.
        drv_req(0, 1'b1, 1'b1, 32'h8, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        drv_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            o = observe(0);
            if (o.resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid_no_resp", 32'(seen), 32'd0);
        txn(0, 1'b0, 32'h8, 32'h0, 0, 32'hA500_0002, 1'b0, acc);

        // Zero wait states: write/read pairs back to back, 3-cycle spacing.
        prev_acc = -1;
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++) begin
                wr = (r == 0);
                txn(1, wr, 32'(i * 4), 32'(i + 1), 0, wr ? 32'd0 : 32'(i + 1), 1'b0, acc);
                ref_apply(1, wr, 32'(i * 4), 32'(i + 1));
                if (prev_acc >= 0) chk("w0_spacing", acc - prev_acc, 32'd3);
                prev_acc = acc;
            end
        end

        // Randomised traffic against the word-array model.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                wr    = 1'($urandom_range(0, 1));
                wdata = $urandom;
                case ($urandom_range(0, 7))
                    6:       addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                    7:       addr = ($urandom | 32'h400) & 32'hFFFF_FFFC;
                    default: addr = 32'($urandom_range(0, 15) * 4);
                endcase
                txn(s, wr, addr, wdata, $urandom_range(0, 3),
                    ref_rdata(s, wr, addr), ref_err(addr), acc);
                ref_apply(s, wr, addr, wdata);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
